// File: rtl/instr_encoder.sv
// Token-stream program loader: encodes mnemonic tokens into 16-bit DSP
// instruction words and writes them to consecutive program-memory addresses.
module instr_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              tok_valid,
   output logic              tok_ready,
   input  logic [4:0]        tok_op,
   input  logic [3:0]        tok_shift,
   input  logic [7:0]        tok_arg,
   input  logic              tok_last,
   output logic              pm_we,
   output logic [ADDR_W-1:0] pm_addr,
   output logic [15:0]       pm_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_WRITE, S_DONE, S_ERROR} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [ADDR_W-1:0]   pm_addr_q, pm_addr_d;
   logic [15:0]         pm_wdata_q, pm_wdata_d;
   logic [1:0]          err_code_q, err_code_d;
   logic                last_q, last_d;

   logic [15:0]         enc_word;
   logic                op_illegal, op_fixed, op_shift, op_direct, range_err;
   logic [7:0]          dir_arg;

   assign dir_arg = {1'b0, tok_arg[6:0]};

   always_comb begin
      enc_word   = 16'h0000;
      op_illegal = 1'b0;
      op_fixed   = 1'b0;
      op_shift   = 1'b0;
      op_direct  = 1'b1;
      case (tok_op)
         5'd0:  begin enc_word = 16'h7F88; op_fixed = 1'b1; op_direct = 1'b0; end
         5'd1:  begin enc_word = {4'h0, tok_shift, dir_arg}; op_shift = 1'b1; end
         5'd2:  enc_word = {8'h60, dir_arg};
         5'd3:  enc_word = {8'h61, dir_arg};
         5'd4:  enc_word = {8'h79, dir_arg};
         5'd5:  begin enc_word = 16'h7F8F; op_fixed = 1'b1; op_direct = 1'b0; end
         5'd6:  begin enc_word = {4'h2, tok_shift, dir_arg}; op_shift = 1'b1; end
         5'd7:  begin enc_word = {8'h7E, tok_arg}; op_direct = 1'b0; end
         5'd8:  enc_word = {8'h6F, dir_arg};
         5'd9:  enc_word = {8'h6A, dir_arg};
         5'd10: enc_word = {8'h6C, dir_arg};
         5'd11: enc_word = {8'h6D, dir_arg};
         5'd12: enc_word = {8'h7A, dir_arg};
         5'd13: begin enc_word = 16'h7F8E; op_fixed = 1'b1; op_direct = 1'b0; end
         5'd14: begin enc_word = 16'h7F90; op_fixed = 1'b1; op_direct = 1'b0; end
         5'd15: begin enc_word = {4'h1, tok_shift, dir_arg}; op_shift = 1'b1; end
         5'd16: begin enc_word = 16'h7F89; op_fixed = 1'b1; op_direct = 1'b0; end
         default: begin op_illegal = 1'b1; op_direct = 1'b0; end
      endcase
   end

   // Fixed-word ops ignore both fields; LACK takes a full 8-bit constant.
   assign range_err = (op_direct && tok_arg[7]) ||
                      (!op_fixed && !op_shift && (tok_shift != 4'h0));

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      pm_addr_d  = pm_addr_q;
      pm_wdata_d = pm_wdata_q;
      err_code_d = err_code_q;
      last_d     = last_q;
      if (start) begin
         state_d    = S_RUN;
         addr_d     = base_addr;
         count_d    = '0;
         err_code_d = 2'd0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (tok_valid) begin
                  if (op_illegal) begin
                     state_d    = S_ERROR;
                     err_code_d = 2'd1;
                  end else if (range_err) begin
                     state_d    = S_ERROR;
                     err_code_d = 2'd2;
                  end else if (count_q == DEPTH_C) begin
                     state_d    = S_ERROR;
                     err_code_d = 2'd3;
                  end else begin
                     pm_wdata_d = enc_word;
                     pm_addr_d  = addr_q;
                     last_d     = tok_last;
                     state_d    = S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               addr_d  = addr_q + 1'b1;
               count_d = count_q + 1'b1;
               state_d = last_q ? S_DONE : S_RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         pm_addr_q  <= '0;
         pm_wdata_q <= '0;
         err_code_q <= 2'd0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         pm_addr_q  <= pm_addr_d;
         pm_wdata_q <= pm_wdata_d;
         err_code_q <= err_code_d;
         last_q     <= last_d;
      end
   end

   assign tok_ready  = (state_q == S_RUN);
   assign pm_we      = (state_q == S_WRITE);
   assign busy       = (state_q == S_RUN) || (state_q == S_WRITE);
   assign done       = (state_q == S_DONE);
   assign err        = (state_q == S_ERROR);
   assign err_code   = err_code_q;
   assign pm_addr    = pm_addr_q;
   assign pm_wdata   = pm_wdata_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder; DEPTH is reduced to 4 so the memory-full
// path is reachable with a short token stream.
module tb_instr_encoder;

   logic       clk = 1'b0;
   logic       reset, start, tok_valid, tok_last;
   logic [7:0] base_addr, tok_arg;
   logic [4:0] tok_op;
   logic [3:0] tok_shift;
   logic       tok_ready, pm_we, busy, done, err;
   logic [7:0] pm_addr;
   logic [15:0] pm_wdata;
   logic [1:0] err_code;
   logic [8:0] word_count;

   int checks = 0;
   int failures = 0;
   int wr_cnt = 0;
   int wr_snap;

   instr_encoder #(.ADDR_W(8), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_op(tok_op),
      .tok_shift(tok_shift), .tok_arg(tok_arg), .tok_last(tok_last),
      .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata), .busy(busy),
      .done(done), .err(err), .err_code(err_code), .word_count(word_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (pm_we) wr_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] base);
      start = 1'b1;
      base_addr = base;
      tick();
      start = 1'b0;
      chk("start_ready", tok_ready, 1);
      chk("start_clear", {done, err, err_code}, 0);
   endtask

   // Presents a token, waits for acceptance, returns in the cycle after it.
   task automatic send(input logic [4:0] op, input logic [3:0] sh,
                       input logic [7:0] arg, input logic last);
      tok_op = op; tok_shift = sh; tok_arg = arg; tok_last = last;
      tok_valid = 1'b1;
      for (int i = 0; i < 20 && !tok_ready; i++) tick();
      if (!tok_ready) chk("ready_timeout", 0, 1);
      tick();
      tok_valid = 1'b0;
   endtask

   logic [4:0]  s_op   [4] = '{5'd7, 5'd11, 5'd0, 5'd16};
   logic [3:0]  s_sh   [4] = '{4'd0, 4'd0, 4'd5, 4'd0};
   logic [7:0]  s_arg  [4] = '{8'hAB, 8'h10, 8'h55, 8'h00};
   logic [15:0] s_exp  [4] = '{16'h7EAB, 16'h6D10, 16'h7F88, 16'h7F89};
   logic [4:0]  f_op   [4] = '{5'd6, 5'd15, 5'd12, 5'd9};
   logic [3:0]  f_sh   [4] = '{4'hF, 4'h1, 4'h0, 4'h0};
   logic [7:0]  f_arg  [4] = '{8'h7F, 8'h02, 8'h33, 8'h44};
   logic [15:0] f_exp  [4] = '{16'h2F7F, 16'h1102, 16'h7A33, 16'h6A44};
   logic [4:0]  w_op   [3] = '{5'd13, 5'd14, 5'd5};
   logic [15:0] w_exp  [3] = '{16'h7F8E, 16'h7F90, 16'h7F8F};
   logic [7:0]  w_addr [3] = '{8'hFE, 8'hFF, 8'h00};

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; tok_valid = 1'b0;
      tok_op = '0; tok_shift = '0; tok_arg = '0; tok_last = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_ready", tok_ready, 0);
      chk("rst_we", pm_we, 0);
      chk("rst_addr", pm_addr, 0);
      chk("rst_wdata", pm_wdata, 0);
      chk("rst_flags", {busy, done, err, err_code}, 0);
      chk("rst_count", word_count, 0);

      // Single ADD shift 3 arg 0x25
      do_start(8'h10);
      send(5'd1, 4'd3, 8'h25, 1'b1);
      chk("add_we", pm_we, 1);
      chk("add_addr", pm_addr, 8'h10);
      chk("add_data", pm_wdata, 16'h0325);
      chk("add_ready_low", tok_ready, 0);
      tick();
      chk("add_done", done, 1);
      chk("add_count", word_count, 1);
      chk("add_busy", busy, 0);
      chk("add_addr_hold", pm_addr, 8'h10);

      // Streaming with tok_valid held; start cycle must not accept the token
      tok_valid = 1'b1; tok_op = s_op[0]; tok_shift = s_sh[0]; tok_arg = s_arg[0];
      tok_last = 1'b0; start = 1'b1; base_addr = 8'h20;
      tick();
      start = 1'b0;
      chk("stream_start_no_we", pm_we, 0);
      chk("stream_start_ready", tok_ready, 1);
      for (int i = 0; i < 4; i++) begin
         tok_op = s_op[i]; tok_shift = s_sh[i]; tok_arg = s_arg[i]; tok_last = (i == 3);
         tick();
         chk("stream_we", pm_we, 1);
         chk("stream_addr", pm_addr, 8'h20 + i);
         chk("stream_data", pm_wdata, s_exp[i]);
         tick();
         if (i < 3) chk("stream_ready", {tok_ready, pm_we}, 2'b10);
      end
      chk("stream_done", done, 1);
      chk("stream_count", word_count, 4);
      wr_snap = wr_cnt;
      tick(); tick();
      chk("done_no_accept", wr_cnt, wr_snap);
      chk("done_ready", tok_ready, 0);
      tok_valid = 1'b0;

      // Illegal op
      do_start(8'h00);
      wr_snap = wr_cnt;
      send(5'd20, 4'd0, 8'h00, 1'b0);
      chk("illegal_err", {err, err_code}, 3'b101);
      chk("illegal_busy", busy, 0);
      tok_op = 5'd1; tok_shift = 4'd0; tok_arg = 8'h01; tok_valid = 1'b1;
      tick(); tick(); tick();
      tok_valid = 1'b0;
      chk("illegal_no_write", wr_cnt, wr_snap);
      chk("illegal_hold", {tok_ready, err, err_code}, 4'b0101);

      // Range errors
      do_start(8'h00);
      send(5'd1, 4'd0, 8'h80, 1'b0);
      chk("range_arg", {err, err_code}, 3'b110);
      do_start(8'h00);
      send(5'd4, 4'd2, 8'h01, 1'b0);
      chk("range_shift", {err, err_code}, 3'b110);
      chk("range_no_write", wr_cnt, wr_snap);

      // Memory full at DEPTH=4
      do_start(8'h30);
      for (int i = 0; i < 4; i++) begin
         send(f_op[i], f_sh[i], f_arg[i], 1'b0);
         chk("full_addr", pm_addr, 8'h30 + i);
         chk("full_data", pm_wdata, f_exp[i]);
      end
      tick();
      chk("full_count4", word_count, 4);
      wr_snap = wr_cnt;
      send(5'd2, 4'd0, 8'h01, 1'b0);
      chk("full_err", {err, err_code}, 3'b111);
      chk("full_no_write", wr_cnt, wr_snap);
      chk("full_count", word_count, 4);

      // Restart mid-stream, start landing during the WRITE cycle
      do_start(8'h50);
      send(5'd3, 4'd0, 8'h11, 1'b0);
      chk("mid_data0", pm_wdata, 16'h6111);
      send(5'd8, 4'd0, 8'h05, 1'b0);
      chk("mid_we1", {pm_we, pm_addr}, {1'b1, 8'h51});
      start = 1'b1; base_addr = 8'h40;
      tick();
      start = 1'b0;
      chk("mid_restart", {tok_ready, pm_we, busy}, 3'b101);
      chk("mid_count0", word_count, 0);
      send(5'd10, 4'd0, 8'h7F, 1'b1);
      chk("mid_addr", pm_addr, 8'h40);
      chk("mid_data", pm_wdata, 16'h6C7F);
      tick();
      chk("mid_count1", word_count, 1);
      chk("mid_done", {done, err}, 2'b10);

      // Address wrap
      do_start(8'hFE);
      for (int i = 0; i < 3; i++) begin
         send(w_op[i], 4'h7, 8'hFF, i == 2);
         chk("wrap_addr", pm_addr, w_addr[i]);
         chk("wrap_data", pm_wdata, w_exp[i]);
      end
      tick();
      chk("wrap_done", {done, word_count}, {1'b1, 9'd3});

      // Reset during WRITE
      do_start(8'h60);
      send(5'd2, 4'd0, 8'h12, 1'b0);
      chk("rstw_we", pm_we, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstw_out", {tok_ready, pm_we, busy, done, err, err_code}, 0);
      chk("rstw_addr", pm_addr, 0);
      chk("rstw_data", pm_wdata, 0);
      chk("rstw_count", word_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
